// File: rtl/stopwatch_minsec_if.sv
// stopwatch_minsec_if: button inputs and count/display outputs
// of the minutes/seconds stopwatch stage.
interface stopwatch_minsec_if;
  logic       btn_ss;
  logic       btn_lap;
  logic       running;
  logic       carry;
  logic [5:0] sec_bin;
  logic [5:0] min_bin;
  logic [6:0] seg_s1;
  logic [6:0] seg_s10;
  logic [6:0] seg_m1;
  logic [6:0] seg_m10;

  modport master (
    output btn_ss, btn_lap,
    input  running, carry, sec_bin, min_bin,
    input  seg_s1, seg_s10, seg_m1, seg_m10
  );

  modport slave (
    input  btn_ss, btn_lap,
    output running, carry, sec_bin, min_bin,
    output seg_s1, seg_s10, seg_m1, seg_m10
  );
endinterface

// File: rtl/stopwatch_minsec.sv
// stopwatch_minsec: debounced start/stop + lap/clear control,
// mm:ss counter with wrap carry and 7-segment display.
module stopwatch_minsec #(
  parameter int TICK_DIV  = 250000,
  parameter int DB_CYCLES = 50000
) (
  input logic clk,
  input logic reset,
  stopwatch_minsec_if.slave bus
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(DB_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, LAP} state_t;

  state_t          state;
  logic [1:0]      s0, s1, db, db_q, press;
  logic [DW-1:0]   dcnt [2];
  logic [PW-1:0]   pre;
  logic [5:0]      sec, min, snap_sec, snap_min;
  logic            carry;
  logic [6:0]      seg_s1, seg_s10, seg_m1, seg_m10;
  logic            ss, lp, active, tick, clr;
  logic [5:0]      disp_sec, disp_min;
  logic [3:0]      s_one, s_ten, m_one, m_ten;

  // ss has priority: a coincident lap press is dropped
  assign ss     = press[0];
  assign lp     = press[1] & ~press[0];
  assign active = (state == RUN) || (state == LAP);
  assign tick   = active && (pre == PW'(TICK_DIV - 1));
  assign clr    = (state == PAUSE) && lp;

  // two-flop synchronisers, index 0 = ss, 1 = lap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s0 <= '0;
      s1 <= '0;
    end else begin
      s0 <= {bus.btn_lap, bus.btn_ss};
      s1 <= s0;
    end
  end

  // debounce: level flips after DB_CYCLES stable mismatches
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db   <= '0;
      db_q <= '0;
      press <= '0;
      for (int i = 0; i < 2; i++) dcnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (s1[i] == db[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DW'(DB_CYCLES - 1)) begin
          dcnt[i] <= '0;
          db[i]   <= s1[i];
        end else begin
          dcnt[i] <= dcnt[i] + 1'b1;
        end
      end
      db_q  <= db;
      press <= db & ~db_q;
    end
  end

  // control FSM with lap snapshot of the pre-edge count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      snap_sec <= '0;
      snap_min <= '0;
    end else begin
      unique case (state)
        IDLE: if (ss) state <= RUN;
        RUN: begin
          if (ss) begin
            state <= PAUSE;
          end else if (lp) begin
            state    <= LAP;
            snap_sec <= sec;
            snap_min <= min;
          end
        end
        LAP: begin
          if (ss)      state <= PAUSE;
          else if (lp) state <= RUN;
        end
        PAUSE: begin
          if (ss) begin
            state <= RUN;
          end else if (lp) begin
            state    <= IDLE;
            snap_sec <= '0;
            snap_min <= '0;
          end
        end
      endcase
    end
  end

  // prescaler: runs while active, holds in PAUSE, zero in IDLE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre <= '0;
    end else if (state == IDLE || clr) begin
      pre <= '0;
    end else if (active) begin
      pre <= tick ? '0 : pre + 1'b1;
    end
  end

  // mm:ss count with one-cycle carry on 59:59 wrap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sec   <= '0;
      min   <= '0;
      carry <= 1'b0;
    end else begin
      carry <= 1'b0;
      if (clr) begin
        sec <= '0;
        min <= '0;
      end else if (tick) begin
        if (sec == 6'd59) begin
          sec <= '0;
          if (min == 6'd59) begin
            min   <= '0;
            carry <= 1'b1;
          end else begin
            min <= min + 1'b1;
          end
        end else begin
          sec <= sec + 1'b1;
        end
      end
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b0000001;
      4'd1:    seg7 = 7'b1001111;
      4'd2:    seg7 = 7'b0010010;
      4'd3:    seg7 = 7'b0000110;
      4'd4:    seg7 = 7'b1001100;
      4'd5:    seg7 = 7'b0100100;
      4'd6:    seg7 = 7'b0100000;
      4'd7:    seg7 = 7'b0001111;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0000100;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  assign disp_sec = (state == LAP) ? snap_sec : sec;
  assign disp_min = (state == LAP) ? snap_min : min;
  assign s_ten    = 4'(disp_sec / 6'd10);
  assign s_one    = 4'(disp_sec % 6'd10);
  assign m_ten    = 4'(disp_min / 6'd10);
  assign m_one    = 4'(disp_min % 6'd10);

  // registered segment decode of the displayed value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_s1  <= 7'b0000001;
      seg_s10 <= 7'b0000001;
      seg_m1  <= 7'b0000001;
      seg_m10 <= 7'b0000001;
    end else begin
      seg_s1  <= seg7(s_one);
      seg_s10 <= seg7(s_ten);
      seg_m1  <= seg7(m_one);
      seg_m10 <= seg7(m_ten);
    end
  end

  assign bus.running = active;
  assign bus.carry   = carry;
  assign bus.sec_bin = sec;
  assign bus.min_bin = min;
  assign bus.seg_s1  = seg_s1;
  assign bus.seg_s10 = seg_s10;
  assign bus.seg_m1  = seg_m1;
  assign bus.seg_m10 = seg_m10;

endmodule

// File: tb/tb_stopwatch_minsec.sv
// tb_stopwatch_minsec: directed bench for the mm:ss stopwatch
// stage with TICK_DIV=4, DB_CYCLES=3.
module tb_stopwatch_minsec;

  localparam logic [6:0] D0 = 7'b0000001;
  localparam logic [6:0] D1 = 7'b1001111;
  localparam logic [6:0] D2 = 7'b0010010;
  localparam logic [6:0] D3 = 7'b0000110;
  localparam logic [6:0] D7 = 7'b0001111;
  localparam logic [6:0] D8 = 7'b0000000;
  localparam logic [6:0] D9 = 7'b0000100;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   fails = 0;
  int   cyc = 0;
  int   carries = 0;

  stopwatch_minsec_if bus ();

  stopwatch_minsec #(
    .TICK_DIV (4),
    .DB_CYCLES(3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
    cyc++;
    if (bus.carry === 1'b1) carries++;
  endtask

  task automatic press(input logic ss, input logic lp, input int hold);
    bus.btn_ss  = ss;
    bus.btn_lap = lp;
    repeat (hold) step();
    bus.btn_ss  = 1'b0;
    bus.btn_lap = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    checks++;
    if ({bus.running, bus.carry, bus.sec_bin, bus.min_bin} !== 14'd0) begin
      $display("FAIL reset_cnt: got run=%b c=%b s=%0d m=%0d want 0",
               bus.running, bus.carry, bus.sec_bin, bus.min_bin);
      fails++;
    end
    checks++;
    if ({bus.seg_m10, bus.seg_m1, bus.seg_s10, bus.seg_s1} !== {D0, D0, D0, D0}) begin
      $display("FAIL reset_seg: got %h want %h",
               {bus.seg_m10, bus.seg_m1, bus.seg_s10, bus.seg_s1}, {D0, D0, D0, D0});
      fails++;
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_start_count();
    cyc = 0;
    carries = 0;
    bus.btn_ss = 1'b1;
    repeat (6) step();
    checks++;
    if (bus.running !== 1'b0) begin
      $display("FAIL start_early: running got %b want 0", bus.running);
      fails++;
    end
    step();
    checks++;
    if (bus.running !== 1'b1) begin
      $display("FAIL start_run: running got %b want 1", bus.running);
      fails++;
    end
    repeat (3) step();
    bus.btn_ss = 1'b0;
    step();
    checks++;
    if (bus.sec_bin !== 6'd1) begin
      $display("FAIL first_tick: sec got %0d want 1", bus.sec_bin);
      fails++;
    end
    while (cyc < 246) step();
    checks++;
    if ({bus.min_bin, bus.sec_bin} !== {6'd0, 6'd59}) begin
      $display("FAIL cnt_0059: got %0d:%0d want 0:59", bus.min_bin, bus.sec_bin);
      fails++;
    end
    step();
    checks++;
    if ({bus.min_bin, bus.sec_bin} !== {6'd1, 6'd0} || bus.seg_s1 !== D9) begin
      $display("FAIL cnt_0100: got %0d:%0d seg_s1=%b want 1:0 seg_s1=%b",
               bus.min_bin, bus.sec_bin, bus.seg_s1, D9);
      fails++;
    end
    step();
    checks++;
    if ({bus.seg_m10, bus.seg_m1, bus.seg_s10, bus.seg_s1} !== {D0, D1, D0, D0}) begin
      $display("FAIL seg_0100: got %h want %h",
               {bus.seg_m10, bus.seg_m1, bus.seg_s10, bus.seg_s1}, {D0, D1, D0, D0});
      fails++;
    end
  endtask

  task automatic test_wrap();
    while (cyc < 14406) step();
    checks++;
    if ({bus.min_bin, bus.sec_bin, bus.carry} !== {6'd59, 6'd59, 1'b0}) begin
      $display("FAIL pre_wrap: got %0d:%0d c=%b want 59:59 c=0",
               bus.min_bin, bus.sec_bin, bus.carry);
      fails++;
    end
    step();
    checks++;
    if ({bus.min_bin, bus.sec_bin, bus.carry} !== {6'd0, 6'd0, 1'b1}) begin
      $display("FAIL wrap: got %0d:%0d c=%b want 0:0 c=1",
               bus.min_bin, bus.sec_bin, bus.carry);
      fails++;
    end
    step();
    checks++;
    if (bus.carry !== 1'b0) begin
      $display("FAIL carry_width: carry got %b want 0", bus.carry);
      fails++;
    end
    checks++;
    if (carries != 1) begin
      $display("FAIL carry_count: got %0d pulses want 1", carries);
      fails++;
    end
  endtask

  task automatic test_pause_clear();
    press(1'b1, 1'b0, 10);
    checks++;
    if ({bus.running, bus.min_bin, bus.sec_bin} !== {1'b0, 6'd0, 6'd2}) begin
      $display("FAIL pause: got run=%b %0d:%0d want run=0 0:2",
               bus.running, bus.min_bin, bus.sec_bin);
      fails++;
    end
    repeat (20) step();
    checks++;
    if (bus.sec_bin !== 6'd2) begin
      $display("FAIL pause_hold: sec got %0d want 2", bus.sec_bin);
      fails++;
    end
    press(1'b0, 1'b1, 10);
    checks++;
    if ({bus.running, bus.min_bin, bus.sec_bin} !== 13'd0) begin
      $display("FAIL clear: got run=%b %0d:%0d want run=0 0:0",
               bus.running, bus.min_bin, bus.sec_bin);
      fails++;
    end
    repeat (2) step();
    checks++;
    if ({bus.seg_m10, bus.seg_m1, bus.seg_s10, bus.seg_s1} !== {D0, D0, D0, D0}) begin
      $display("FAIL clear_seg: got %h want %h",
               {bus.seg_m10, bus.seg_m1, bus.seg_s10, bus.seg_s1}, {D0, D0, D0, D0});
      fails++;
    end
    bus.btn_ss = 1'b1;
    repeat (2) step();
    bus.btn_ss = 1'b0;
    repeat (12) step();
    checks++;
    if (bus.running !== 1'b0 || bus.sec_bin !== 6'd0) begin
      $display("FAIL glitch: got run=%b sec=%0d want run=0 sec=0",
               bus.running, bus.sec_bin);
      fails++;
    end
  endtask

  task automatic test_lap();
    cyc = 0;
    press(1'b1, 1'b0, 10);
    checks++;
    if (bus.running !== 1'b1) begin
      $display("FAIL lap_start: running got %b want 1", bus.running);
      fails++;
    end
    while (cyc < 30) step();
    bus.btn_lap = 1'b1;
    while (cyc < 40) step();
    bus.btn_lap = 1'b0;
    checks++;
    if ({bus.running, bus.seg_s10, bus.seg_s1} !== {1'b1, D0, D7}) begin
      $display("FAIL lap_frozen: got run=%b s10=%b s1=%b want run=1 s10=%b s1=%b",
               bus.running, bus.seg_s10, bus.seg_s1, D0, D7);
      fails++;
    end
    while (cyc < 50) step();
    checks++;
    if (bus.sec_bin !== 6'd10 || bus.seg_s1 !== D7) begin
      $display("FAIL lap_live: got sec=%0d s1=%b want sec=10 s1=%b",
               bus.sec_bin, bus.seg_s1, D7);
      fails++;
    end
    bus.btn_lap = 1'b1;
    while (cyc < 57) step();
    checks++;
    if (bus.seg_s1 !== D7) begin
      $display("FAIL lap_exit_lag: s1 got %b want %b", bus.seg_s1, D7);
      fails++;
    end
    step();
    checks++;
    if ({bus.seg_s10, bus.seg_s1} !== {D1, D2}) begin
      $display("FAIL lap_exit: got s10=%b s1=%b want s10=%b s1=%b",
               bus.seg_s10, bus.seg_s1, D1, D2);
      fails++;
    end
    repeat (2) step();
    bus.btn_lap = 1'b0;
    checks++;
    if (bus.seg_s1 !== D3 || bus.running !== 1'b1) begin
      $display("FAIL lap_track: got s1=%b run=%b want s1=%b run=1",
               bus.seg_s1, bus.running, D3);
      fails++;
    end
  endtask

  task automatic test_simultaneous();
    while (cyc < 72) step();
    press(1'b1, 1'b1, 10);
    checks++;
    if ({bus.running, bus.min_bin, bus.sec_bin} !== {1'b0, 6'd0, 6'd18}) begin
      $display("FAIL simul_state: got run=%b %0d:%0d want run=0 0:18",
               bus.running, bus.min_bin, bus.sec_bin);
      fails++;
    end
    checks++;
    if ({bus.seg_s10, bus.seg_s1} !== {D1, D8}) begin
      $display("FAIL simul_disp: got s10=%b s1=%b want s10=%b s1=%b",
               bus.seg_s10, bus.seg_s1, D1, D8);
      fails++;
    end
  endtask

  task automatic test_reset_midrun();
    press(1'b1, 1'b0, 10);
    repeat (5) step();
    bus.btn_ss = 1'b1;
    repeat (4) step();
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({bus.running, bus.carry, bus.sec_bin, bus.min_bin} !== 14'd0) begin
      $display("FAIL midrun_rst: got run=%b c=%b s=%0d m=%0d want 0",
               bus.running, bus.carry, bus.sec_bin, bus.min_bin);
      fails++;
    end
    checks++;
    if ({bus.seg_m10, bus.seg_m1, bus.seg_s10, bus.seg_s1} !== {D0, D0, D0, D0}) begin
      $display("FAIL midrun_seg: got %h want %h",
               {bus.seg_m10, bus.seg_m1, bus.seg_s10, bus.seg_s1}, {D0, D0, D0, D0});
      fails++;
    end
    bus.btn_ss = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    repeat (15) step();
    checks++;
    if ({bus.running, bus.carry, bus.sec_bin} !== 8'd0) begin
      $display("FAIL post_rst: got run=%b c=%b sec=%0d want 0",
               bus.running, bus.carry, bus.sec_bin);
      fails++;
    end
  endtask

  initial begin
    bus.btn_ss  = 1'b0;
    bus.btn_lap = 1'b0;
    test_reset();
    test_start_count();
    test_wrap();
    test_pause_clear();
    test_lap();
    test_simultaneous();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: run did not complete");
    $fatal(1, "timeout");
  end

endmodule
